// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op/state encodings, default memory width and decode helpers for the load/store unit
package lsu_pkg;
  localparam int ADDR_W_DEF = 11;
  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;
  function automatic logic is_load(op_t op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction
  function automatic logic is_partial_store(op_t op);
    return op inside {OP_SH, OP_SB};
  endfunction
  function automatic logic is_misaligned(op_t op, logic [1:0] lo);
    return ((op == OP_LW || op == OP_SW) && lo != 2'd0) ||
           ((op == OP_LH || op == OP_LHU || op == OP_SH) && lo[0]);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extraction with sign/zero extension, and lane merge for partial stores
module lsu_align
  import lsu_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  lo,
  input  logic [31:0] rword,
  input  logic [31:0] mword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask;
  logic [31:0] hmask;
  logic [31:0] hins;
  // pick the addressed lane out of the read word and extend it; splice store data into the captured word
  always_comb begin
    sh = {lo, 3'b000};
    b = 8'(rword >> sh);
    h = lo[1] ? rword[31:16] : rword[15:0];
    load_data = op == OP_LW  ? rword :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'h0000, h} :
                op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'h000000, b} : 32'h0;
    bmask = 32'h0000_00FF << sh;
    hmask = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    hins = lo[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
    merge_data = op == OP_SB ? (mword & ~bmask) | ({24'h000000, wdata[7:0]} << sh) :
                 op == OP_SH ? (mword & ~hmask) | hins : mword;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit driving a word-wide memory with read-modify-write for sub-word stores
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_wena,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  state_t            state;
  op_t               op;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       word;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              req_mis;
  lsu_align u_align (
    .op         (op),
    .lo         (addr[1:0]),
    .rword      (dm_rdata),
    .mword      (word),
    .wdata      (wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );
  // handshake, write strobe and write data decoded from state so a reset drops the write at once
  always_comb begin
    req_mis = is_misaligned(op_t'(req_op), req_addr[1:0]);
    req_ready = state == S_IDLE;
    resp_valid = state == S_RESP;
    dm_addr = addr[ADDR_W+1:2];
    dm_wena = state == S_MERGE || (state == S_ACCESS && op == OP_SW);
    dm_wdata = state == S_MERGE ? merge_data :
               (state == S_ACCESS && op == OP_SW) ? wdata : 32'h0;
  end
  // request sequencing: accept, access memory, optionally merge, then a one-cycle response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op <= OP_LW;
      addr <= '0;
      wdata <= 32'h0;
      word <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          op <= op_t'(req_op);
          addr <= req_addr[ADDR_W+1:0];
          wdata <= req_wdata;
          resp_rdata <= 32'h0;
          resp_err <= req_mis;
          state <= req_mis ? S_RESP : S_ACCESS;
        end
        S_ACCESS: begin
          word <= dm_rdata;
          resp_rdata <= is_load(op) ? load_data : 32'h0;
          state <= is_partial_store(op) ? S_MERGE : S_RESP;
        end
        S_MERGE: state <= S_RESP;
        default: begin
          resp_rdata <= 32'h0;
          resp_err <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: byte-level reference model and per-cycle compare of the load/store unit, directed cases plus random ops
module tb_mem_lsu;
  localparam int AW = 11;
  localparam int NW = 2 ** AW;
  localparam int LW = 0, LH = 1, LHU = 2, LB = 3, LBU = 4, SW = 5, SH = 6, SB = 7;
  logic clk = 0, rst = 1, req_valid = 0;
  logic req_ready, resp_valid, resp_err, dm_wena;
  logic [2:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;
  logic [31:0] mem [NW];
  logic [7:0] mb [4*NW];
  int checks = 0, errors = 0, cyc = 0;
  int acc_cyc = 0, exp_cyc = 0, exp_wcyc = 0, acc_count = 0, resp_count = 0, wena_count = 0, last_lat = 0;
  bit chk_en = 0, pending = 0, exp_wr = 0, exp_err = 0, last_err = 0, due, wexp;
  logic [31:0] exp_rdata = 0, exp_wword = 0, last_rdata = 0;
  logic [AW-1:0] exp_waddr = 0;

  mem_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_wena(dm_wena), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dm_wena) mem[dm_addr] <= dm_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) mb[4*w+i] = v[8*i+:8];
  endtask

  // reference: what the accepted request must produce, from byte-addressed memory semantics
  task automatic record(input int op, input logic [31:0] addr, input logic [31:0] wd);
    int a, lat;
    bit mis;
    logic [31:0] rd;
    a = int'(addr[AW+1:0]);
    rd = 0;
    mis = ((op == LW || op == SW) && a % 4 != 0) || ((op == LH || op == LHU || op == SH) && a % 2 != 0);
    lat = mis ? 1 : (op == SH || op == SB) ? 3 : 2;
    if (!mis) begin
      case (op)
        LW:  rd = mword(a / 4);
        LH:  rd = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
        LHU: rd = {16'h0, mb[a+1], mb[a]};
        LB:  rd = {{24{mb[a][7]}}, mb[a]};
        LBU: rd = {24'h0, mb[a]};
        SW:  for (int i = 0; i < 4; i++) mb[a+i] = wd[8*i+:8];
        SH:  begin mb[a] = wd[7:0]; mb[a+1] = wd[15:8]; end
        default: mb[a] = wd[7:0];
      endcase
    end
    acc_cyc = cyc + 1;
    exp_cyc = acc_cyc + lat - 1;
    exp_wcyc = acc_cyc + lat - 2;
    exp_wr = !mis && op >= SW;
    exp_waddr = AW'(a / 4);
    exp_wword = mword(a / 4);
    exp_rdata = rd;
    exp_err = mis;
    pending = 1;
    acc_count++;
  endtask

  // every cycle: handshake, write strobe/data and response must match the reference
  always @(negedge clk) if (chk_en && !rst) begin
    due = pending && cyc == exp_cyc;
    wexp = pending && exp_wr && cyc == exp_wcyc;
    if (dm_wena) wena_count++;
    chk("resp_valid", 32'(resp_valid), 32'(due));
    chk("req_ready", 32'(req_ready), 32'(!(pending && cyc >= acc_cyc)));
    chk("dm_wena", 32'(dm_wena), 32'(wexp));
    chk("dm_wdata", dm_wdata, wexp ? exp_wword : 32'h0);
    if (wexp) chk("dm_addr", 32'(dm_addr), 32'(exp_waddr));
    if (resp_valid) begin
      resp_count++;
      last_rdata = resp_rdata;
      last_err = resp_err;
      last_lat = cyc - acc_cyc + 1;
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
    if (due) pending = 0;
  end

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] wd);
    req_op = 3'(op);
    req_addr = a;
    req_wdata = wd;
    req_valid = 1;
  endtask

  task automatic wait_accept;
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout t=%0t", $time);
    end else record(int'(req_op), req_addr, req_wdata);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp;
    int n = 0;
    while (pending && n < 20) begin @(posedge clk); #1; n++; end
    if (pending) begin
      errors++;
      pending = 0;
      $display("FAIL resp_timeout t=%0t", $time);
    end
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] wd);
    drive(op, a, wd);
    wait_accept();
    req_valid = 0;
    wait_resp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved, ra;
    int a1, w0;
    bit rv;
    for (int i = 0; i < NW; i++) set_word(i, $urandom);
    set_word(3, 32'h11223344);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_dm_wena", 32'(dm_wena), 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    issue(SB, 32'h0D, 32'hAA);
    chk("sb_lat", 32'(last_lat), 3);
    chk("sb_err", 32'(last_err), 0);
    chk("sb_mem", mem[3], 32'h1122AA44);
    chk("sb_model", mword(3), 32'h1122AA44);
    issue(LB, 32'h0D, 0);
    chk("lb_data", last_rdata, 32'hFFFFFFAA);
    chk("lb_lat", 32'(last_lat), 2);
    issue(LBU, 32'h0D, 0);
    chk("lbu_data", last_rdata, 32'h000000AA);
    issue(LH, 32'h0E, 0);
    chk("lh_data", last_rdata, 32'h00001122);
    saved = mem[1];
    w0 = wena_count;
    issue(SW, 32'h06, 32'hCAFEF00D);
    chk("mis_err", 32'(last_err), 1);
    chk("mis_lat", 32'(last_lat), 1);
    chk("mis_rdata", last_rdata, 0);
    chk("mis_mem", mem[1], saved);
    chk("mis_no_wena", 32'(wena_count), 32'(w0));
    drive(SW, 32'h10, 32'hDEADBEEF);
    wait_accept();
    a1 = acc_cyc;
    drive(LW, 32'h10, 0);
    wait_accept();
    chk("b2b_accept_cycle", 32'(acc_cyc), 32'(a1 + 3));
    req_valid = 0;
    wait_resp();
    chk("b2b_lw", last_rdata, 32'hDEADBEEF);
    chk_en = 0;
    saved = mem[4];
    chk("rst_pre_ready", 32'(req_ready), 1);
    drive(SH, 32'h12, 32'h5555);
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("merge_wena_pre", 32'(dm_wena), 1);
    rst = 1;
    #1;
    chk("abort_wena", 32'(dm_wena), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    @(negedge clk); #1;
    chk("abort_mem", mem[4], saved);
    @(posedge clk); #1;
    rst = 0;
    rv = 0;
    repeat (4) begin @(negedge clk); rv |= resp_valid; end
    chk("abort_no_resp", 32'(rv), 0);
    chk("abort_ready_after", 32'(req_ready), 1);
    @(posedge clk); #1;
    chk_en = 1;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      ra[12:6] = '0;
      issue(int'($urandom_range(0, 7)), ra, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    chk("resp_pulse_count", 32'(resp_count), 32'(acc_count));
    for (int i = 0; i < NW; i++) if (mem[i] !== mword(i)) chk($sformatf("mem_word_%0d", i), mem[i], mword(i));
    chk("mem_word_0", mem[0], mword(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
